// File: rtl/fx_glide_pkg.sv
// Shared constants for the glide effect: FSM state encodings, glide direction and tick dividers.
package fx_glide_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV   = 2'd1;
  localparam logic [1:0] ST_GLIDE = 2'd2;

  localparam int TICK_DIV_IMPL = 3187500;
  localparam int TICK_DIV_SIM  = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/fx_glide_if.sv
// Note-event bus between the note decoder (master) and the glide effect (slave).
interface fx_glide_if #(
  parameter int NOTE_W  = 6,
  parameter int STEPS_W = 8
);
  logic               i_en;
  logic [NOTE_W-1:0]  i_note_in;
  logic               i_note_valid;
  logic [STEPS_W-1:0] i_glide_steps;
  logic [NOTE_W-1:0]  o_note_out;
  logic               o_busy;

  modport master (
    output i_en, i_note_in, i_note_valid, i_glide_steps,
    input  o_note_out, o_busy
  );

  modport slave (
    input  i_en, i_note_in, i_note_valid, i_glide_steps,
    output o_note_out, o_busy
  );
endinterface

// File: rtl/fx_glide_div.sv
// Restoring unsigned divider, one quotient bit per cycle; o_done pulses for one cycle with the result.
module glide_div #(
  parameter int DW = 14,
  parameter int SW = 8
) (
  input  logic          clk50mhz,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [DW-1:0] i_dividend,
  input  logic [SW-1:0] i_divisor,
  output logic [DW-1:0] o_quotient,
  output logic          o_done
);
  localparam int CW = $clog2(DW + 1);

  logic [SW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [SW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_done;

  logic [SW:0] w_shift;
  logic [SW:0] w_trial;
  logic        w_ge;

  assign w_shift = {r_rem, r_quo[DW-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_trial = w_shift - {1'b0, r_div};

  // The partial remainder always stays below the divisor, so SW bits hold it after each step.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_run <= 1'b0;
      end else if (i_start) begin
        r_rem <= '0;
        r_quo <= i_dividend;
        r_div <= i_divisor;
        r_cnt <= CW'(DW);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_ge ? w_trial[SW-1:0] : w_shift[SW-1:0];
        r_quo <= {r_quo[DW-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;
endmodule

// File: rtl/fx_glide.sv
// Portamento effect: walks a fixed-point pitch position toward each new target note, one step per tick.
module fx_glide
  import fx_glide_pkg::*;
#(
  parameter int NOTE_W   = 6,
  parameter int FRAC_W   = 8,
  parameter int STEPS_W  = 8,
  parameter int TICK_DIV = TICK_DIV_IMPL
) (
  input logic       clk50mhz,
  input logic       rst,
  fx_glide_if.slave bus
);
  localparam int PW  = NOTE_W + FRAC_W;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PSW-1:0]    r_presc;
  logic [PW-1:0]     r_pos;
  logic [PW-1:0]     r_step;
  logic [NOTE_W-1:0] r_target;
  dir_e              r_dir;
  logic [1:0]        r_state;
  logic              r_first;

  logic              w_tick;
  logic [PW:0]       w_round_sum;
  logic [NOTE_W-1:0] w_round;
  logic [PW-1:0]     w_new_pos;
  logic [PW-1:0]     w_tgt_pos;
  logic              w_new_up;
  logic [PW-1:0]     w_dividend;
  logic [PW:0]       w_up_sum;
  logic [PW-1:0]     w_down_gap;
  logic              w_idle_ev;
  logic              w_retrig;
  logic              w_jump;
  logic              w_start;
  logic              w_abort;
  logic [PW-1:0]     w_quo;
  logic              w_done;

  assign w_tick = (r_presc == PSW'(TICK_DIV - 1));

  always_ff @(posedge clk50mhz) begin
    if (rst || w_tick) r_presc <= '0;
    else               r_presc <= r_presc + 1'b1;
  end

  // Round to nearest note; only a position above the top note plus one half can carry out.
  assign w_round_sum = {1'b0, r_pos} + (PW+1)'(1 << (FRAC_W - 1));
  assign w_round     = w_round_sum[PW] ? '1 : w_round_sum[PW-1:FRAC_W];

  assign w_new_pos  = {bus.i_note_in, {FRAC_W{1'b0}}};
  assign w_tgt_pos  = {r_target, {FRAC_W{1'b0}}};
  assign w_new_up   = w_new_pos > r_pos;
  assign w_dividend = w_new_up ? (w_new_pos - r_pos) : (r_pos - w_new_pos);
  assign w_up_sum   = {1'b0, r_pos} + {1'b0, r_step};
  assign w_down_gap = r_pos - w_tgt_pos;

  assign w_idle_ev = bus.i_en && bus.i_note_valid && (r_state == ST_IDLE);
  assign w_retrig  = bus.i_en && bus.i_note_valid && (r_state != ST_IDLE) && (bus.i_note_in != r_target);
  assign w_jump    = (w_idle_ev && (r_first || bus.i_glide_steps == '0))
                   || (w_retrig && bus.i_glide_steps == '0);
  assign w_start   = !w_jump && ((w_idle_ev && bus.i_note_in != w_round) || w_retrig);
  assign w_abort   = !bus.i_en || w_jump;

  glide_div #(
    .DW(PW),
    .SW(STEPS_W)
  ) u_div (
    .clk50mhz   (clk50mhz),
    .rst        (rst),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_dividend (w_dividend),
    .i_divisor  (bus.i_glide_steps),
    .o_quotient (w_quo),
    .o_done     (w_done)
  );

  // A note event outranks a coincident tick, so that tick's step is simply dropped.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      r_pos    <= '0;
      r_step   <= '0;
      r_target <= '0;
      r_dir    <= DIR_DOWN;
      r_state  <= ST_IDLE;
      r_first  <= 1'b1;
    end else if (!bus.i_en) begin
      r_pos   <= '0;
      r_state <= ST_IDLE;
      r_first <= 1'b1;
    end else if (w_jump) begin
      r_pos   <= w_new_pos;
      r_state <= ST_IDLE;
      r_first <= 1'b0;
    end else if (w_start) begin
      r_target <= bus.i_note_in;
      r_dir    <= w_new_up ? DIR_UP : DIR_DOWN;
      r_state  <= ST_DIV;
    end else begin
      case (r_state)
        ST_DIV: begin
          if (w_done) begin
            r_step  <= (w_quo == '0) ? PW'(1) : w_quo;
            r_state <= ST_GLIDE;
          end
        end
        ST_GLIDE: begin
          if (w_tick) begin
            if (r_dir == DIR_UP) begin
              if (w_up_sum >= {1'b0, w_tgt_pos}) begin
                r_pos   <= w_tgt_pos;
                r_state <= ST_IDLE;
              end else begin
                r_pos <= w_up_sum[PW-1:0];
              end
            end else begin
              if (w_down_gap <= r_step) begin
                r_pos   <= w_tgt_pos;
                r_state <= ST_IDLE;
              end else begin
                r_pos <= r_pos - r_step;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_note_out = w_round;
  assign bus.o_busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_fx_glide.sv
// Directed bench for fx_glide: expected note sequences are queued on each note event and popped as note_out moves.
module tb_fx_glide;
  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [5:0] expQ[$];
  logic [5:0] prevNote;

  fx_glide_if #(.NOTE_W(6), .STEPS_W(8)) bus ();

  fx_glide #(
    .NOTE_W   (6),
    .FRAC_W   (8),
    .STEPS_W  (8),
    .TICK_DIV (4)
  ) dut (
    .clk50mhz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] note, input logic [7:0] steps);
    @(negedge clk);
    bus.i_note_in     = note;
    bus.i_glide_steps = steps;
    bus.i_note_valid  = 1'b1;
    @(negedge clk);
    bus.i_note_valid  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pop each queued note as note_out changes; a missing change within the budget is a failure.
  task automatic drainGlide(input string tag, input int maxCycles);
    int n;
    logic [5:0] exp;
    prevNote = bus.o_note_out;
    while (expQ.size() > 0) begin
      n = 0;
      while (bus.o_note_out === prevNote && n < maxCycles) begin
        @(negedge clk);
        n++;
      end
      exp = expQ.pop_front();
      if (n >= maxCycles) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_timeout observed=%0d expected=%0d", tag, bus.o_note_out, exp);
        expQ.delete();
      end else begin
        checkOutput(tag, 32'(bus.o_note_out), 32'(exp));
        prevNote = bus.o_note_out;
      end
    end
  endtask

  initial begin
    int n;
    rst               = 1'b1;
    bus.i_en          = 1'b0;
    bus.i_note_in     = '0;
    bus.i_note_valid  = 1'b0;
    bus.i_glide_steps = '0;
    idleCycles(3);
    checkOutput("reset_note", 32'(bus.o_note_out), 32'd0);
    checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
    rst      = 1'b0;
    bus.i_en = 1'b1;
    idleCycles(2);

    applyStimulus(6'd10, 8'd4);
    checkOutput("first_note", 32'(bus.o_note_out), 32'd10);
    checkOutput("first_busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(6'd30, 8'd4);
    checkOutput("up_busy", 32'(bus.o_busy), 32'd1);
    expQ.push_back(6'd15); expQ.push_back(6'd20); expQ.push_back(6'd25); expQ.push_back(6'd30);
    drainGlide("glide_up", 60);
    checkOutput("up_done_busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(6'd22, 8'd4);
    expQ.push_back(6'd28); expQ.push_back(6'd26); expQ.push_back(6'd24); expQ.push_back(6'd22);
    drainGlide("glide_down", 60);
    idleCycles(12);
    checkOutput("down_hold", 32'(bus.o_note_out), 32'd22);
    checkOutput("down_busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(6'd23, 8'd255);
    idleCycles(900);
    checkOutput("slow_busy_mid", 32'(bus.o_busy), 32'd1);
    checkOutput("slow_note_mid", 32'(bus.o_note_out), 32'd23);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("slow_busy_end", 32'(bus.o_busy), 32'd0);
    idleCycles(8);
    checkOutput("slow_land", 32'(bus.o_note_out), 32'd23);

    applyStimulus(6'd10, 8'd0);
    checkOutput("jump10", 32'(bus.o_note_out), 32'd10);
    applyStimulus(6'd30, 8'd4);
    expQ.push_back(6'd15); expQ.push_back(6'd20);
    drainGlide("pre_retrig", 60);
    applyStimulus(6'd5, 8'd3);
    checkOutput("retrig_busy", 32'(bus.o_busy), 32'd1);
    expQ.push_back(6'd15);
    drainGlide("retrig", 60);
    applyStimulus(6'd5, 8'd3);
    expQ.push_back(6'd10); expQ.push_back(6'd5);
    drainGlide("same_target", 60);
    checkOutput("retrig_done_busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(6'd40, 8'd4);
    expQ.push_back(6'd14);
    drainGlide("pre_mute", 60);
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    checkOutput("mute_note", 32'(bus.o_note_out), 32'd0);
    checkOutput("mute_busy", 32'(bus.o_busy), 32'd0);
    bus.i_en = 1'b1;

    applyStimulus(6'd5, 8'd4);
    checkOutput("after_mute_jump", 32'(bus.o_note_out), 32'd5);
    applyStimulus(6'd40, 8'd4);
    expQ.push_back(6'd14);
    drainGlide("pre_reset", 60);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_note", 32'(bus.o_note_out), 32'd0);
    checkOutput("midreset_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;

    applyStimulus(6'd40, 8'd0);
    checkOutput("jump40", 32'(bus.o_note_out), 32'd40);
    checkOutput("jump40_busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(6'd63, 8'd0);
    checkOutput("jump63", 32'(bus.o_note_out), 32'd63);
    applyStimulus(6'd0, 8'd4);
    expQ.push_back(6'd47); expQ.push_back(6'd32); expQ.push_back(6'd16); expQ.push_back(6'd0);
    drainGlide("to_zero", 60);
    idleCycles(12);
    checkOutput("zero_hold", 32'(bus.o_note_out), 32'd0);
    checkOutput("zero_busy", 32'(bus.o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
